// File: rtl/video_pkg.sv
// Shared video timing defaults and sync-bit indices for the scandoubler path.
package video_pkg;
    localparam int DEF_DIV    = 4;
    localparam int DEF_HCW    = 10;
    localparam int DEF_LCW    = 10;
    localparam int DEF_HMIN   = 600;
    localparam int DEF_HMAX   = 720;
    localparam int DEF_VMIN   = 250;
    localparam int DEF_VMAX   = 330;
    localparam int DEF_STABLE = 3;
    localparam bit DEF_EN     = 1'b1;

    // isync bit positions
    localparam int HS = 0;
    localparam int VS = 1;
endpackage

// File: rtl/scandoubler_ctrl_if.sv
// Sync/enable bundle between the video generator, the controller and the doubler.
interface scandoubler_ctrl_if #(
    parameter int HCW = 10,
    parameter int LCW = 10
);
    logic [1:0]     isync;
    logic           toggle;
    logic           ice;
    logic           oce;
    logic           enable;
    logic           locked;
    logic [HCW-1:0] hperiod;
    logic [LCW-1:0] vlines;

    // master: video source side; slave: the controller
    modport master (output isync, toggle,
                    input  ice, oce, enable, locked, hperiod, vlines);
    modport slave  (input  isync, toggle,
                    output ice, oce, enable, locked, hperiod, vlines);
endinterface

// File: rtl/ce_divider.sv
// Free-running divider producing one-clock ice (period DIV) and oce (period DIV/2).
module ce_divider #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic ice,
    output logic oce
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            ice <= 1'b0;
            oce <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            ice <= (cnt == LAST);
            oce <= (cnt == LAST) || (cnt == HALF);
        end
    end
endmodule

// File: rtl/scandoubler_ctrl.sv
// Scandoubler sequencer: pixel clock enables, line/frame measurement, lock
// detection and frame-aligned doubler enable.
module scandoubler_ctrl
    import video_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int HCW        = DEF_HCW,
    parameter int LCW        = DEF_LCW,
    parameter int HMIN       = DEF_HMIN,
    parameter int HMAX       = DEF_HMAX,
    parameter int VMIN       = DEF_VMIN,
    parameter int VMAX       = DEF_VMAX,
    parameter int STABLE     = DEF_STABLE,
    parameter bit EN_DEFAULT = DEF_EN
) (
    input logic               clock,
    input logic               reset,
    scandoubler_ctrl_if.slave bus
);
    localparam logic [HCW-1:0] H_LO = HCW'(HMIN);
    localparam logic [HCW-1:0] H_HI = HCW'(HMAX);
    localparam logic [LCW-1:0] V_LO = LCW'(VMIN);
    localparam logic [LCW-1:0] V_HI = LCW'(VMAX);
    localparam logic [2:0]     ST   = 3'(STABLE);

    logic           ice, oce;
    logic [1:0]     prev;
    logic [HCW-1:0] hcnt, hcnt_inc, hperiod;
    logic [LCW-1:0] lcnt, lcnt_inc, vlines;
    logic [2:0]     stable, stable_nx;
    logic           hs_rise, vs_rise, timeout, valid;
    logic           locked, locked_nx, enable, user_en;

    ce_divider #(.DIV(DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .ice   (ice),
        .oce   (oce)
    );

    assign bus.ice     = ice;
    assign bus.oce     = oce;
    assign bus.enable  = enable;
    assign bus.locked  = locked;
    assign bus.hperiod = hperiod;
    assign bus.vlines  = vlines;

    always_comb begin
        hs_rise   = ice & ~prev[HS] & bus.isync[HS];
        vs_rise   = ice & ~prev[VS] & bus.isync[VS];
        hcnt_inc  = (hcnt == '1) ? hcnt : hcnt + 1'b1;
        lcnt_inc  = (lcnt == '1) ? lcnt : lcnt + 1'b1;
        timeout   = (hcnt == '1);
        // lcnt is the value vlines takes on this vsync tick
        valid     = (lcnt >= V_LO) && (lcnt <= V_HI) &&
                    (hperiod >= H_LO) && (hperiod <= H_HI);
        stable_nx = stable;
        if (vs_rise)
            stable_nx = valid ? ((stable == ST) ? stable : stable + 3'd1) : 3'd0;
        if (timeout)
            stable_nx = 3'd0;
        // rising lock lags one ice behind the counter; losing it is immediate
        locked_nx = (stable == ST) && (stable_nx == ST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev    <= '0;
            hcnt    <= '0;
            lcnt    <= '0;
            hperiod <= '0;
            vlines  <= '0;
            stable  <= '0;
            locked  <= 1'b0;
            enable  <= 1'b0;
            user_en <= EN_DEFAULT;
        end else begin
            if (bus.toggle)
                user_en <= ~user_en;
            stable <= stable_nx;
            if (ice || timeout)
                locked <= locked_nx;
            if (timeout)
                enable <= 1'b0;
            else if (vs_rise)
                enable <= locked_nx & user_en;
            if (ice) begin
                prev <= bus.isync;
                if (hs_rise) begin
                    hperiod <= hcnt_inc;
                    hcnt    <= '0;
                end else begin
                    hcnt    <= hcnt_inc;
                end
                // a coincident hsync rise is the first line of the new frame
                if (vs_rise) begin
                    vlines <= lcnt;
                    lcnt   <= hs_rise ? LCW'(1) : '0;
                end else if (hs_rise) begin
                    lcnt   <= lcnt_inc;
                end
            end
        end
    end
endmodule
